mem_port_arbiter: RTL and testbench

- Shares the single memory port between instruction fetch (IF) and load/store (LSU) requesters in the multi-cycle/pipelined RISC-V core.
- The memory port uses a req/gnt handshake with a response (rvalid) that arrives one or more cycles later.
- Exactly one transaction is outstanding at a time.
- LSU has priority; a streak limit prevents fetch starvation.

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_arb_streak_cnt.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the IF/LSU memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE_IF,
      ISSUE_LSU,
      WAIT_IF,
      WAIT_LSU
   } arb_state_t;

   typedef enum logic {
      OWN_IF,
      OWN_LSU
   } owner_t;

   localparam int unsigned DEFAULT_MAX_LSU_STREAK = 4;

   // Bits needed to count 0..max_streak inclusive.
   function automatic int unsigned streak_width(input int unsigned max_streak);
      return (max_streak < 1) ? 1 : $clog2(max_streak + 1);
   endfunction

   localparam int unsigned STREAK_W = streak_width(DEFAULT_MAX_LSU_STREAK);

endpackage

// File: rtl/mem_arb_streak_cnt.sv
// Saturating count of consecutive LSU grants taken while IF was waiting.
module mem_arb_streak_cnt
   import mem_arb_pkg::*;
#(
   parameter int unsigned MAX = DEFAULT_MAX_LSU_STREAK,
   parameter int unsigned W   = streak_width(MAX)
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic inc_i,
   output logic at_limit_o
);

   localparam logic [W-1:0] MAX_V = W'(MAX);

   logic [W-1:0] cnt_q, cnt_d;

   // Next count: clear wins over increment; increment holds at MAX.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != MAX_V)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_limit_o = (cnt_q == MAX_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one req/gnt/rvalid memory port between instruction fetch and the
// load/store unit. One transaction outstanding at a time; LSU has priority,
// but after MAX_LSU_STREAK back-to-back LSU wins over a waiting fetch the
// fetch is forced through.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned MAX_LSU_STREAK = DEFAULT_MAX_LSU_STREAK,
   parameter int unsigned AW             = 32,
   parameter int unsigned DW             = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   // instruction fetch
   input  logic            if_req_i,
   input  logic [AW-1:0]   if_addr_i,
   output logic            if_gnt_o,
   output logic            if_rvalid_o,
   output logic [DW-1:0]   if_rdata_o,
   // load/store
   input  logic            lsu_req_i,
   input  logic            lsu_we_i,
   input  logic [DW/8-1:0] lsu_be_i,
   input  logic [AW-1:0]   lsu_addr_i,
   input  logic [DW-1:0]   lsu_wdata_i,
   output logic            lsu_gnt_o,
   output logic            lsu_rvalid_o,
   output logic [DW-1:0]   lsu_rdata_o,
   // memory port
   output logic            mem_req_o,
   output logic            mem_we_o,
   output logic [DW/8-1:0] mem_be_o,
   output logic [AW-1:0]   mem_addr_o,
   output logic [DW-1:0]   mem_wdata_o,
   input  logic            mem_gnt_i,
   input  logic            mem_rvalid_i,
   input  logic [DW-1:0]   mem_rdata_i,
   // status
   output logic            busy_o,
   output logic            spurious_rsp_o
);

   arb_state_t state_q, state_d;
   owner_t     owner;
   logic       req;
   logic       if_rsp;
   logic       lsu_rsp;
   logic       spurious;
   logic       at_limit;

   // Arbitration, ownership lock and response routing.
   always_comb begin
      state_d  = state_q;
      owner    = OWN_IF;
      req      = 1'b0;
      if_rsp   = 1'b0;
      lsu_rsp  = 1'b0;
      spurious = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (lsu_req_i && !(if_req_i && at_limit)) begin
               owner = OWN_LSU;
               req   = 1'b1;
            end else if (if_req_i) begin
               owner = OWN_IF;
               req   = 1'b1;
            end
            if (req) begin
               if (owner == OWN_LSU) state_d = mem_gnt_i ? WAIT_LSU : ISSUE_LSU;
               else                  state_d = mem_gnt_i ? WAIT_IF  : ISSUE_IF;
            end
            spurious = mem_rvalid_i;
         end
         ISSUE_IF: begin
            owner    = OWN_IF;
            req      = 1'b1;
            spurious = mem_rvalid_i;
            if (mem_gnt_i) state_d = WAIT_IF;
         end
         ISSUE_LSU: begin
            owner    = OWN_LSU;
            req      = 1'b1;
            spurious = mem_rvalid_i;
            if (mem_gnt_i) state_d = WAIT_LSU;
         end
         WAIT_IF: begin
            if_rsp = mem_rvalid_i;
            if (mem_rvalid_i) state_d = IDLE;
         end
         WAIT_LSU: begin
            lsu_rsp = mem_rvalid_i;
            if (mem_rvalid_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Hold every output quiet while reset is asserted, whatever the inputs do.
      if (!rst_ni) begin
         req      = 1'b0;
         if_rsp   = 1'b0;
         lsu_rsp  = 1'b0;
         spurious = 1'b0;
      end
   end

   // FSM state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Memory-side field mux; everything reads zero when no request is driven.
   always_comb begin
      mem_req_o   = req;
      mem_we_o    = 1'b0;
      mem_be_o    = '0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (req) begin
         if (owner == OWN_LSU) begin
            mem_we_o    = lsu_we_i;
            mem_be_o    = lsu_be_i;
            mem_addr_o  = lsu_addr_i;
            mem_wdata_o = lsu_wdata_i;
         end else begin
            mem_be_o    = '1;  // fetches always read the full word
            mem_addr_o  = if_addr_i;
         end
      end
   end

   assign if_gnt_o       = req && (owner == OWN_IF)  && mem_gnt_i;
   assign lsu_gnt_o      = req && (owner == OWN_LSU) && mem_gnt_i;
   assign if_rvalid_o    = if_rsp;
   assign lsu_rvalid_o   = lsu_rsp;
   assign if_rdata_o     = if_rsp  ? mem_rdata_i : '0;
   assign lsu_rdata_o    = lsu_rsp ? mem_rdata_i : '0;
   assign busy_o         = rst_ni && ((state_q != IDLE) || req);
   assign spurious_rsp_o = spurious;

   mem_arb_streak_cnt #(
      .MAX (MAX_LSU_STREAK),
      .W   (streak_width(MAX_LSU_STREAK))
   ) u_streak (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clr_i      (if_gnt_o || (lsu_gnt_o && !if_req_i)),
      .inc_i      (lsu_gnt_o && if_req_i),
      .at_limit_o (at_limit)
   );

   // A requester that has been locked in as owner must keep requesting until granted.
   assert property (@(posedge clk_i) disable iff (!rst_ni) (state_q == ISSUE_IF)  |-> if_req_i);
   assert property (@(posedge clk_i) disable iff (!rst_ni) (state_q == ISSUE_LSU) |-> lsu_req_i);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change 1 ns after the rising
// edge and outputs are compared 1 ns later, well clear of the next edge.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic            clk_i;
   logic            rst_ni;
   logic            if_req_i;
   logic [AW-1:0]   if_addr_i;
   logic            if_gnt_o;
   logic            if_rvalid_o;
   logic [DW-1:0]   if_rdata_o;
   logic            lsu_req_i;
   logic            lsu_we_i;
   logic [DW/8-1:0] lsu_be_i;
   logic [AW-1:0]   lsu_addr_i;
   logic [DW-1:0]   lsu_wdata_i;
   logic            lsu_gnt_o;
   logic            lsu_rvalid_o;
   logic [DW-1:0]   lsu_rdata_o;
   logic            mem_req_o;
   logic            mem_we_o;
   logic [DW/8-1:0] mem_be_o;
   logic [AW-1:0]   mem_addr_o;
   logic [DW-1:0]   mem_wdata_o;
   logic            mem_gnt_i;
   logic            mem_rvalid_i;
   logic [DW-1:0]   mem_rdata_i;
   logic            busy_o;
   logic            spurious_rsp_o;

   int n_checks = 0;
   int n_fail   = 0;

   mem_port_arbiter #(
      .MAX_LSU_STREAK (4),
      .AW             (AW),
      .DW             (DW)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .if_req_i       (if_req_i),
      .if_addr_i      (if_addr_i),
      .if_gnt_o       (if_gnt_o),
      .if_rvalid_o    (if_rvalid_o),
      .if_rdata_o     (if_rdata_o),
      .lsu_req_i      (lsu_req_i),
      .lsu_we_i       (lsu_we_i),
      .lsu_be_i       (lsu_be_i),
      .lsu_addr_i     (lsu_addr_i),
      .lsu_wdata_i    (lsu_wdata_i),
      .lsu_gnt_o      (lsu_gnt_o),
      .lsu_rvalid_o   (lsu_rvalid_o),
      .lsu_rdata_o    (lsu_rdata_o),
      .mem_req_o      (mem_req_o),
      .mem_we_o       (mem_we_o),
      .mem_be_o       (mem_be_o),
      .mem_addr_o     (mem_addr_o),
      .mem_wdata_o    (mem_wdata_o),
      .mem_gnt_i      (mem_gnt_i),
      .mem_rvalid_i   (mem_rvalid_i),
      .mem_rdata_i    (mem_rdata_i),
      .busy_o         (busy_o),
      .spurious_rsp_o (spurious_rsp_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clr_lsu();
      lsu_req_i   = 1'b0;
      lsu_we_i    = 1'b0;
      lsu_be_i    = '0;
      lsu_addr_i  = '0;
      lsu_wdata_i = '0;
   endtask

   task automatic set_lsu(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata);
      lsu_req_i   = 1'b1;
      lsu_we_i    = we;
      lsu_be_i    = be;
      lsu_addr_i  = addr;
      lsu_wdata_i = wdata;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".mem_req"},   mem_req_o,      0);
      check({tag, ".mem_we"},    mem_we_o,       0);
      check({tag, ".mem_be"},    mem_be_o,       0);
      check({tag, ".mem_addr"},  mem_addr_o,     0);
      check({tag, ".mem_wdata"}, mem_wdata_o,    0);
      check({tag, ".if_gnt"},    if_gnt_o,       0);
      check({tag, ".lsu_gnt"},   lsu_gnt_o,      0);
      check({tag, ".if_rvalid"}, if_rvalid_o,    0);
      check({tag, ".if_rdata"},  if_rdata_o,     0);
      check({tag, ".lsu_rvld"},  lsu_rvalid_o,   0);
      check({tag, ".lsu_rdata"}, lsu_rdata_o,    0);
      check({tag, ".busy"},      busy_o,         0);
      check({tag, ".spurious"},  spurious_rsp_o, 0);
   endtask

   // Grant pattern for the streak-reset run: IF drops out on the third grant.
   logic [7:0] sr_if_req  = 8'b1111_1011;  // bit j = if_req during grant j
   logic [7:0] sr_exp_lsu = 8'b0111_1111;  // bit j = LSU expected to win grant j

   initial begin
      rst_ni       = 1'b0;
      if_req_i     = 1'b0;
      if_addr_i    = '0;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      clr_lsu();

      // ---------------- reset state ----------------
      tick();
      check_all_zero("reset");
      check("reset.state", dut.state_q, IDLE);
      tick();
      rst_ni = 1'b1;

      // ---------------- single fetch ----------------
      tick();  // cycle 0: request, granted immediately
      if_req_i  = 1'b1;
      if_addr_i = 32'h0000_0100;
      mem_gnt_i = 1'b1;
      settle();
      check("fetch.c0.gnt",  if_gnt_o,   1);
      check("fetch.c0.req",  mem_req_o,  1);
      check("fetch.c0.addr", mem_addr_o, 32'h0000_0100);
      check("fetch.c0.we",   mem_we_o,   0);
      check("fetch.c0.be",   mem_be_o,   4'hF);
      check("fetch.c0.busy", busy_o,     1);
      tick();  // cycle 1: waiting
      if_req_i  = 1'b0;
      if_addr_i = '0;
      mem_gnt_i = 1'b0;
      settle();
      check("fetch.c1.req",    mem_req_o,   0);
      check("fetch.c1.addr",   mem_addr_o,  0);
      check("fetch.c1.rvalid", if_rvalid_o, 0);
      check("fetch.c1.busy",   busy_o,      1);
      tick();  // cycle 2: response
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h0000_0513;
      settle();
      check("fetch.c2.rvalid",   if_rvalid_o,    1);
      check("fetch.c2.rdata",    if_rdata_o,     32'h0000_0513);
      check("fetch.c2.lsu_rvld", lsu_rvalid_o,   0);
      check("fetch.c2.busy",     busy_o,         1);
      check("fetch.c2.spur",     spurious_rsp_o, 0);
      tick();  // cycle 3: back to idle
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      settle();
      check("fetch.c3.busy",  busy_o,     0);
      check("fetch.c3.rdata", if_rdata_o, 0);

      // ---------------- simultaneous IF + LSU store ----------------
      tick();
      if_req_i  = 1'b1;
      if_addr_i = 32'h0000_0104;
      set_lsu(1'b1, 4'b0011, 32'h0000_2000, 32'hDEAD_BEEF);
      mem_gnt_i = 1'b1;
      settle();
      check("simul.lsu_gnt", lsu_gnt_o,   1);
      check("simul.if_gnt",  if_gnt_o,    0);
      check("simul.we",      mem_we_o,    1);
      check("simul.be",      mem_be_o,    4'b0011);
      check("simul.addr",    mem_addr_o,  32'h0000_2000);
      check("simul.wdata",   mem_wdata_o, 32'hDEAD_BEEF);
      tick();  // WAIT_LSU, IF still pending
      clr_lsu();
      mem_gnt_i = 1'b0;
      settle();
      check("simul.wait.req",    mem_req_o, 0);
      check("simul.wait.if_gnt", if_gnt_o,  0);
      tick();  // store ack
      mem_rvalid_i = 1'b1;
      settle();
      check("simul.ack.lsu_rvld", lsu_rvalid_o, 1);
      check("simul.ack.if_gnt",   if_gnt_o,     0);
      tick();  // cycle after ack: IF wins
      mem_rvalid_i = 1'b0;
      mem_gnt_i    = 1'b1;
      settle();
      check("simul.if.gnt",  if_gnt_o,   1);
      check("simul.if.addr", mem_addr_o, 32'h0000_0104);
      check("simul.if.we",   mem_we_o,   0);
      tick();
      if_req_i  = 1'b0;
      if_addr_i = '0;
      mem_gnt_i = 1'b0;
      tick();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h0000_0013;
      settle();
      check("simul.if.rdata", if_rdata_o, 32'h0000_0013);
      tick();
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;

      // ---------------- grant stall with locked IF ownership ----------------
      if_req_i  = 1'b1;  // stall cycle 0
      if_addr_i = 32'h0000_0108;
      settle();
      check("stall.c0.req",  mem_req_o,  1);
      check("stall.c0.gnt",  if_gnt_o,   0);
      check("stall.c0.addr", mem_addr_o, 32'h0000_0108);
      tick();  // stall cycle 1: LSU load appears
      set_lsu(1'b0, 4'hF, 32'h0000_3000, 32'h0);
      settle();
      check("stall.c1.addr",    mem_addr_o, 32'h0000_0108);
      check("stall.c1.lsu_gnt", lsu_gnt_o,  0);
      tick();  // stall cycle 2
      settle();
      check("stall.c2.addr",    mem_addr_o, 32'h0000_0108);
      check("stall.c2.lsu_gnt", lsu_gnt_o,  0);
      tick();  // memory finally grants IF
      mem_gnt_i = 1'b1;
      settle();
      check("stall.c3.if_gnt",  if_gnt_o,   1);
      check("stall.c3.lsu_gnt", lsu_gnt_o,  0);
      check("stall.c3.addr",    mem_addr_o, 32'h0000_0108);
      tick();
      if_req_i  = 1'b0;
      if_addr_i = '0;
      mem_gnt_i = 1'b0;
      settle();
      check("stall.wait.lsu_gnt", lsu_gnt_o, 0);
      tick();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h0010_0093;
      settle();
      check("stall.rsp.if_rvld",  if_rvalid_o,  1);
      check("stall.rsp.lsu_rvld", lsu_rvalid_o, 0);
      check("stall.rsp.lsu_gnt",  lsu_gnt_o,    0);
      tick();  // LSU load now issues
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      mem_gnt_i    = 1'b1;
      settle();
      check("stall.lsu.gnt",  lsu_gnt_o,  1);
      check("stall.lsu.addr", mem_addr_o, 32'h0000_3000);
      check("stall.lsu.we",   mem_we_o,   0);
      tick();
      clr_lsu();
      mem_gnt_i = 1'b0;

      // ---------------- load return routing ----------------
      tick();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hCAFE_F00D;
      settle();
      check("load.lsu_rvld",  lsu_rvalid_o, 1);
      check("load.lsu_rdata", lsu_rdata_o,  32'hCAFE_F00D);
      check("load.if_rvld",   if_rvalid_o,  0);
      check("load.if_rdata",  if_rdata_o,   0);
      tick();
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;

      // ---------------- starvation guard: LSUx4, IF, LSUx4, IF ----------------
      if_req_i  = 1'b1;
      if_addr_i = 32'h0000_0200;
      for (int i = 0; i < 10; i++) begin
         set_lsu(1'b0, 4'hF, 32'h0000_5000 + 32'(i * 4), 32'h0);
         mem_gnt_i    = 1'b1;
         mem_rvalid_i = 1'b0;
         settle();
         check($sformatf("starve.%0d.lsu_gnt", i), lsu_gnt_o, (i % 5 != 4));
         check($sformatf("starve.%0d.if_gnt", i),  if_gnt_o,  (i % 5 == 4));
         tick();
         mem_gnt_i    = 1'b0;
         mem_rvalid_i = 1'b1;
         tick();
      end
      mem_rvalid_i = 1'b0;

      // ---------------- streak cleared when IF is low at an LSU grant ----------------
      for (int j = 0; j < 8; j++) begin
         if_req_i = sr_if_req[j];
         set_lsu(1'b0, 4'hF, 32'h0000_6000 + 32'(j * 4), 32'h0);
         mem_gnt_i    = 1'b1;
         mem_rvalid_i = 1'b0;
         settle();
         check($sformatf("sreset.%0d.lsu_gnt", j), lsu_gnt_o, sr_exp_lsu[j]);
         check($sformatf("sreset.%0d.if_gnt", j),  if_gnt_o,  !sr_exp_lsu[j]);
         tick();
         if (j == 2) check("sreset.cnt_cleared", dut.u_streak.cnt_q, 0);
         mem_gnt_i    = 1'b0;
         mem_rvalid_i = 1'b1;
         tick();
      end
      mem_rvalid_i = 1'b0;
      if_req_i     = 1'b0;
      if_addr_i    = '0;
      clr_lsu();

      // ---------------- reset mid-operation ----------------
      tick();
      set_lsu(1'b0, 4'hF, 32'h0000_4000, 32'h0);
      mem_gnt_i = 1'b1;
      settle();
      check("rstmid.lsu_gnt", lsu_gnt_o, 1);
      tick();
      clr_lsu();
      mem_gnt_i = 1'b0;
      settle();
      check("rstmid.state_wait", dut.state_q, WAIT_LSU);
      rst_ni       = 1'b0;  // asynchronous, between edges
      if_req_i     = 1'b1;
      if_addr_i    = 32'h0000_0300;
      mem_rvalid_i = 1'b1;
      settle();
      check_all_zero("rstmid.in_reset");
      check("rstmid.state_idle", dut.state_q, IDLE);
      if_req_i     = 1'b0;
      if_addr_i    = '0;
      mem_rvalid_i = 1'b0;
      tick();
      rst_ni = 1'b1;
      tick();  // late response after reset
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h0000_1234;
      settle();
      check("rstmid.late.lsu_rvld",  lsu_rvalid_o,   0);
      check("rstmid.late.lsu_rdata", lsu_rdata_o,    0);
      check("rstmid.late.if_rvld",   if_rvalid_o,    0);
      check("rstmid.late.spurious",  spurious_rsp_o, 1);
      check("rstmid.late.busy",      busy_o,         0);
      tick();
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      settle();
      check("rstmid.after.spurious", spurious_rsp_o, 0);
      check("rstmid.after.state",    dut.state_q,    IDLE);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
